// File: rtl/mem_access_unit_pkg.sv
// rtl/mem_access_unit_pkg.sv - shared constants, size codes and FSM states for the load/store stage
package mem_access_unit_pkg;

  localparam int DATA_WIDTH = 32;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_REQ  = 2'b01,
    ST_RESP = 2'b10,
    ST_WB   = 2'b11
  } mau_state_e;

  // Size code 2'b11 behaves as a word, so only bit 1 distinguishes word accesses.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
    if (size == SZ_HALF) return addr_lo[0];
    if (size[1])         return addr_lo != 2'b00;
    return 1'b0;
  endfunction

endpackage

// File: rtl/mem_load_align.sv
// rtl/mem_load_align.sv - extracts the addressed byte/half/word from a read word and extends it
module mem_load_align
  import mem_access_unit_pkg::*;
(
  input  logic [DATA_WIDTH-1:0] rdata_i,
  input  logic [1:0]            addr_lo_i,
  input  logic [1:0]            size_i,
  input  logic                  unsigned_i,
  output logic [DATA_WIDTH-1:0] data_o
);

  logic [DATA_WIDTH-1:0] shifted;

  assign shifted = rdata_i >> {addr_lo_i, 3'b000};

  always_comb begin
    data_o = shifted;
    case (size_i)
      SZ_BYTE: data_o = unsigned_i ? {24'h0, shifted[7:0]}  : {{24{shifted[7]}}, shifted[7:0]};
      SZ_HALF: data_o = unsigned_i ? {16'h0, shifted[15:0]} : {{16{shifted[15]}}, shifted[15:0]};
      default: data_o = shifted;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - load/store stage: memory request/response handshake and write-back result
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int RD_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  in_mem_rd,
  input  logic                  in_mem_wr,
  input  logic [1:0]            in_size,
  input  logic                  in_unsigned,
  input  logic [DATA_WIDTH-1:0] in_addr,
  input  logic [DATA_WIDTH-1:0] in_wdata,
  input  logic [RD_WIDTH-1:0]   in_rd,
  output logic [DATA_WIDTH-1:0] Address,
  output logic                  MemWrite,
  output logic                  MemRead,
  output logic [DATA_WIDTH-1:0] Write_data,
  output logic [3:0]            Write_strb,
  input  logic                  Mem_Req_Ready,
  input  logic [DATA_WIDTH-1:0] Read_data,
  input  logic                  Read_data_Valid,
  output logic                  Read_data_Ready,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [RD_WIDTH-1:0]   out_rd,
  output logic                  out_misalign
);

  mau_state_e            state_q, state_d;
  logic                  is_rd_q, is_rd_d;
  logic                  is_wr_q, is_wr_d;
  logic [1:0]            size_q, size_d;
  logic                  uns_q, uns_d;
  logic [DATA_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [RD_WIDTH-1:0]   rd_q, rd_d;
  logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
  logic                  misalign_q, misalign_d;
  logic [DATA_WIDTH-1:0] load_data;
  logic [3:0]            strb_raw;

  mem_load_align u_align (
    .rdata_i    (Read_data),
    .addr_lo_i  (addr_q[1:0]),
    .size_i     (size_q),
    .unsigned_i (uns_q),
    .data_o     (load_data)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      is_rd_q    <= 1'b0;
      is_wr_q    <= 1'b0;
      size_q     <= 2'b00;
      uns_q      <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rd_q       <= '0;
      out_data_q <= '0;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      is_rd_q    <= is_rd_d;
      is_wr_q    <= is_wr_d;
      size_q     <= size_d;
      uns_q      <= uns_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      rd_q       <= rd_d;
      out_data_q <= out_data_d;
      misalign_q <= misalign_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    is_rd_d    = is_rd_q;
    is_wr_d    = is_wr_q;
    size_d     = size_q;
    uns_d      = uns_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rd_d       = rd_q;
    out_data_d = out_data_q;
    misalign_d = misalign_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          // A simultaneous read and write strobe is resolved as a load.
          is_rd_d    = in_mem_rd;
          is_wr_d    = in_mem_wr & ~in_mem_rd;
          size_d     = in_size;
          uns_d      = in_unsigned;
          addr_d     = in_addr;
          wdata_d    = in_wdata;
          rd_d       = in_rd;
          out_data_d = '0;
          misalign_d = 1'b0;
          if (!in_mem_rd && !in_mem_wr) begin
            out_data_d = in_addr;
            state_d    = ST_WB;
          end else if (is_misaligned(in_size, in_addr[1:0])) begin
            misalign_d = 1'b1;
            state_d    = ST_WB;
          end else begin
            state_d    = ST_REQ;
          end
        end
      end
      ST_REQ: begin
        if (Mem_Req_Ready) state_d = is_rd_q ? ST_RESP : ST_WB;
      end
      ST_RESP: begin
        if (Read_data_Valid) begin
          out_data_d = load_data;
          state_d    = ST_WB;
        end
      end
      ST_WB: begin
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    Write_data = wdata_q;
    strb_raw   = 4'b1111;
    case (size_q)
      SZ_BYTE: begin
        Write_data = {4{wdata_q[7:0]}};
        strb_raw   = 4'b0001 << addr_q[1:0];
      end
      SZ_HALF: begin
        Write_data = {2{wdata_q[15:0]}};
        strb_raw   = 4'b0011 << addr_q[1:0];
      end
      default: begin
        Write_data = wdata_q;
        strb_raw   = 4'b1111;
      end
    endcase
  end

  assign in_ready        = (state_q == ST_IDLE);
  assign MemRead         = (state_q == ST_REQ) && is_rd_q;
  assign MemWrite        = (state_q == ST_REQ) && is_wr_q;
  assign Write_strb      = (state_q == ST_REQ) ? strb_raw : 4'b0000;
  assign Read_data_Ready = (state_q == ST_RESP);
  assign Address         = {addr_q[DATA_WIDTH-1:2], 2'b00};
  assign out_valid       = (state_q == ST_WB);
  assign out_data        = out_data_q;
  assign out_rd          = rd_q;
  assign out_misalign    = misalign_q;

endmodule
